// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/bubble generator driven by per-source counted
// stalls (down-counters) and level holds.
// Optional macro STALL_PERF_EN adds per-source 32-bit stall-cycle counters
// readable through perf_sel; without it perf_cnt is tied to 0.
module stall_ctrl #(
    parameter int                   NUM_SRC   = 4,
    parameter int                   NUM_STAGE = 5,
    parameter int                   CNT_W     = 4,
    parameter logic [3*NUM_SRC-1:0] SRC_STAGE = {3'd3, 3'd3, 3'd1, 3'd0}
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           rdy,
    input  logic [NUM_SRC-1:0]                             req_valid,
    input  logic [NUM_SRC*CNT_W-1:0]                       req_cycles,
    input  logic [NUM_SRC-1:0]                             req_hold,
    input  logic                                           flush,
    input  logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] perf_sel,
    output logic [NUM_STAGE-1:0]                           stall_vec,
    output logic [NUM_STAGE-1:0]                           bubble_vec,
    output logic                                           busy,
    output logic [31:0]                                    perf_cnt
);

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [CNT_W-1:0] cnt     [NUM_SRC];
    logic [CNT_W-1:0] cnt_nxt [NUM_SRC];
    logic [NUM_SRC-1:0] active;

    // Next count: decrement saturating at 0, raised to a longer request only
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            logic [CNT_W-1:0] dec;
            logic [CNT_W-1:0] len;
            dec = (cnt[i] == '0) ? '0 : cnt[i] - 1'b1;
            len = req_cycles[i*CNT_W +: CNT_W];
            cnt_nxt[i] = dec;
            if (req_valid[i] && (len > dec))
                cnt_nxt[i] = len;
        end
    end

    // Counter state: reset beats everything, flush beats requests, rdy=0 freezes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++)
                cnt[i] <= '0;
        end else if (rdy) begin
            for (int unsigned i = 0; i < NUM_SRC; i++)
                cnt[i] <= flush ? '0 : cnt_nxt[i];
        end
    end

    // Source activity and the stage mask each active source imposes
    always_comb begin
        stall_vec = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            active[i] = (cnt[i] != '0) || req_hold[i];
            for (int unsigned k = 0; k < NUM_STAGE; k++) begin
                if (active[i] && ({29'b0, SRC_STAGE[i*3 +: 3]} >= k))
                    stall_vec[k] = 1'b1;
            end
        end
    end

    // A bubble enters the first stage that runs behind a held stage
    always_comb begin
        bubble_vec = '0;
        for (int unsigned k = 1; k < NUM_STAGE; k++)
            bubble_vec[k] = stall_vec[k-1] & ~stall_vec[k];
    end

    assign busy = |stall_vec;

`ifdef STALL_PERF_EN
    logic [31:0] perf_q [NUM_SRC];

    // Saturating stall-cycle counters, one per source
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++)
                perf_q[i] <= '0;
        end else if (rdy) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (active[i] && (perf_q[i] != '1))
                    perf_q[i] <= perf_q[i] + 32'd1;
            end
        end
    end

    // Combinational read; unmatched selects read 0
    always_comb begin
        perf_cnt = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (perf_sel == SEL_W'(i))
                perf_cnt = perf_q[i];
        end
    end
`else
    logic perf_sel_unused;
    assign perf_sel_unused = ^perf_sel;
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: scoreboard bench for stall_ctrl at default parameters.
// A behavioural model (remaining-cycle counts, deepest stalled stage) pushes
// expected outputs each cycle; they are popped and compared against the DUT.
module tb_stall_ctrl;

    localparam int NUM_SRC   = 4;
    localparam int NUM_STAGE = 5;
    localparam int CNT_W     = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     rdy;
    logic [NUM_SRC-1:0]       req_valid;
    logic [NUM_SRC*CNT_W-1:0] req_cycles;
    logic [NUM_SRC-1:0]       req_hold;
    logic                     flush;
    logic [1:0]               perf_sel;
    logic [NUM_STAGE-1:0]     stall_vec;
    logic [NUM_STAGE-1:0]     bubble_vec;
    logic                     busy;
    logic [31:0]              perf_cnt;

    stall_ctrl #(
        .NUM_SRC   (NUM_SRC),
        .NUM_STAGE (NUM_STAGE),
        .CNT_W     (CNT_W),
        .SRC_STAGE ({3'd3, 3'd3, 3'd1, 3'd0})
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .req_valid  (req_valid),
        .req_cycles (req_cycles),
        .req_hold   (req_hold),
        .flush      (flush),
        .perf_sel   (perf_sel),
        .stall_vec  (stall_vec),
        .bubble_vec (bubble_vec),
        .busy       (busy),
        .perf_cnt   (perf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_STAGE-1:0] stall;
        logic [NUM_STAGE-1:0] bubble;
        logic                 busy;
        logic [31:0]          perf;
    } exp_t;

    exp_t  exp_q [$];
    int    n_cmp = 0;
    int    n_err = 0;

    int          src_stage [NUM_SRC] = '{0, 1, 3, 3};
    int          rem       [NUM_SRC];
    longint      pc        [NUM_SRC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cyc_of(input int i);
        logic [NUM_SRC*CNT_W-1:0] v;
        v = req_cycles;
        return int'(v[i*CNT_W +: CNT_W]);
    endfunction

    function automatic bit model_active(input int i);
        return (rem[i] > 0) || req_hold[i];
    endfunction

    // Model expected outputs from current state and inputs
    function automatic exp_t model_out();
        exp_t e;
        int   deepest;
        deepest = -1;
        for (int i = 0; i < NUM_SRC; i++)
            if (model_active(i) && src_stage[i] > deepest) deepest = src_stage[i];
        e = '0;
        for (int k = 0; k < NUM_STAGE; k++)
            if (k <= deepest) e.stall[k] = 1'b1;
        if (deepest >= 0 && deepest < NUM_STAGE - 1) e.bubble[deepest + 1] = 1'b1;
        e.busy = (deepest >= 0);
`ifdef STALL_PERF_EN
        e.perf = 32'(pc[perf_sel]);
`else
        e.perf = 32'd0;
`endif
        return e;
    endfunction

    // Model state update at the clock edge
    task automatic model_edge();
        int nr;
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rem[i] = 0;
                pc[i]  = 0;
            end
        end else if (rdy) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (model_active(i) && pc[i] < 64'hFFFF_FFFF) pc[i]++;
                if (flush) begin
                    rem[i] = 0;
                end else begin
                    nr = (rem[i] > 0) ? rem[i] - 1 : 0;
                    if (req_valid[i] && cyc_of(i) > nr) nr = cyc_of(i);
                    rem[i] = nr;
                end
            end
        end
    endtask

    // Push expectation for this cycle, then pop and compare against DUT
    task automatic sample(input string tag);
        exp_t e;
        #1;
        exp_q.push_back(model_out());
        e = exp_q.pop_front();
        check({tag, ".stall"},  32'(stall_vec),  32'(e.stall));
        check({tag, ".bubble"}, 32'(bubble_vec), 32'(e.bubble));
        check({tag, ".busy"},   32'(busy),       32'(e.busy));
        check({tag, ".perf"},   perf_cnt,        e.perf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid  = '0;
        req_cycles = '0;
        req_hold   = '0;
        flush      = 1'b0;
        rdy        = 1'b1;
    endtask

    task automatic req(input int i, input int n);
        req_valid[i] = 1'b1;
        req_cycles[i*CNT_W +: CNT_W] = CNT_W'(n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        sample("reset");
        check("reset.stall_zero", 32'(stall_vec), 32'd0);
        check("reset.perf_zero", perf_cnt, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        perf_sel = 2'd0;
        idle_inputs();
        for (int i = 0; i < NUM_SRC; i++) begin rem[i] = 0; pc[i] = 0; end
        @(negedge clk);
        do_reset();

        // Counted stall on source 2 (deepest stage 3)
        req(2, 3);
        sample("s2_req");
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            sample("s2_stall");
            check("s2_stall.vec", 32'(stall_vec), 32'h0F);
            check("s2_stall.bub", 32'(bubble_vec), 32'h10);
            tick();
        end
        sample("s2_end");
        check("s2_end.vec", 32'(stall_vec), 32'h00);
        tick();

        // A shorter request never shortens a running stall
        req(0, 5);
        sample("s0_req");
        tick();
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            if (c == 1) req(0, 2);
            sample("s0_ext");
            check("s0_ext.vec", 32'(stall_vec), 32'h01);
            tick();
            idle_inputs();
        end
        sample("s0_end");
        check("s0_end.vec", 32'(stall_vec), 32'h00);
        tick();

        // Level hold takes effect in the same cycle
        for (int c = 0; c < 2; c++) begin
            req_hold[1] = 1'b1;
            sample("hold1");
            check("hold1.vec", 32'(stall_vec), 32'h03);
            check("hold1.bub", 32'(bubble_vec), 32'h04);
            tick();
        end
        idle_inputs();
        sample("hold1_end");
        tick();

        // Flush beats a simultaneous request; hold survives flush
        req(3, 4);
        sample("s3_req");
        tick();
        idle_inputs();
        sample("s3_stall");
        tick();
        flush = 1'b1;
        req(3, 7);
        req_hold[1] = 1'b1;
        sample("flush");
        tick();
        idle_inputs();
        sample("post_flush");
        check("post_flush.vec", 32'(stall_vec), 32'h00);
        tick();

        // rdy=0 freezes the count; ignored flush and request while frozen
        req(0, 3);
        sample("frz_req");
        tick();
        idle_inputs();
        sample("frz_run");
        tick();
        for (int c = 0; c < 4; c++) begin
            rdy = 1'b0;
            if (c == 1) flush = 1'b1;
            if (c == 2) req(0, 9);
            sample("frz_hold");
            check("frz_hold.vec", 32'(stall_vec), 32'h01);
            tick();
            idle_inputs();
        end
        for (int c = 0; c < 2; c++) begin
            sample("frz_resume");
            check("frz_resume.vec", 32'(stall_vec), 32'h01);
            tick();
        end
        sample("frz_end");
        check("frz_end.vec", 32'(stall_vec), 32'h00);
        tick();

        // All sources requested together
        for (int i = 0; i < NUM_SRC; i++) req(i, i + 2);
        sample("all_req");
        tick();
        idle_inputs();
        for (int c = 0; c < 6; c++) begin
            sample("all_run");
            tick();
        end

        // Perf count over 6 active cycles, then reset clears it and the stall
        do_reset();
        perf_sel = 2'd2;
        req(2, 8);
        sample("perf_req");
        tick();
        idle_inputs();
        for (int c = 0; c < 6; c++) begin
            sample("perf_run");
            tick();
        end
        sample("perf_chk");
`ifdef STALL_PERF_EN
        check("perf_six", perf_cnt, 32'd6);
`else
        check("perf_off", perf_cnt, 32'd0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample("perf_after_rst");
        check("perf_after_rst.val", perf_cnt, 32'd0);
        check("abort.vec", 32'(stall_vec), 32'h00);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 49) == 0);
            rdy        = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            req_valid  = NUM_SRC'($urandom_range(0, 15) & $urandom_range(0, 15));
            req_cycles = (NUM_SRC*CNT_W)'($urandom);
            req_hold   = NUM_SRC'($urandom_range(0, 15) & $urandom_range(0, 15)
                                  & $urandom_range(0, 15));
            perf_sel   = 2'($urandom_range(0, 3));
            sample("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
